// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the seq_div iterative divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_partial;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_partial = {i_rem, i_msb};
        o_qbit    = (w_partial >= {1'b0, i_divisor});
        // Result is below the divisor whenever we subtract, so WIDTH bits suffice.
        w_diff    = w_partial[WIDTH-1:0] - i_divisor;
        o_rem     = o_qbit ? w_diff : w_partial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, latency WIDTH.
// Optional SEQ_DIV_ZERO_FLAG_EN adds a registered div_by_zero output.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_ZERO_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_step_rem_in;
    logic             w_step_msb;
    logic [WIDTH-1:0] w_step_div;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;

    // The accepting edge performs the first step from a cleared remainder, so
    // WIDTH steps fit between go and done with no bubble between operations.
    always_comb begin
        w_step_rem_in = r_rem;
        w_step_msb    = r_dvd[WIDTH-1];
        w_step_div    = r_div;
        if (r_state != StRun) begin
            w_step_rem_in = '0;
            w_step_msb    = left[WIDTH-1];
            w_step_div    = right;
        end
    end

    seq_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (w_step_rem_in),
        .i_msb    (w_step_msb),
        .i_divisor(w_step_div),
        .o_rem    (w_step_rem),
        .o_qbit   (w_step_qbit)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                ready    = 1'b1;
                w_accept = go;
                if (go) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_last = (r_cnt == CntW'(WIDTH - 1));
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                ready        = 1'b1;
                done         = 1'b1;
                w_accept     = go;
                w_state_next = go ? StRun : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_dvd       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Quotient bits shift into the vacated low end of the dividend.
                r_dvd <= {left[WIDTH-2:0], w_step_qbit};
                r_div <= right;
                r_rem <= w_step_rem;
                r_cnt <= CntW'(1);
            end else if (r_state == StRun) begin
                r_dvd <= {r_dvd[WIDTH-2:0], w_step_qbit};
                r_rem <= w_step_rem;
                r_cnt <= r_cnt + CntW'(1);
                if (w_last) begin
                    r_quotient  <= {r_dvd[WIDTH-2:0], w_step_qbit};
                    r_remainder <= w_step_rem;
                end
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic r_dbz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= (right == '0);
        end
    end

    assign div_by_zero = r_dbz;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=8) against an arithmetic reference model.
module tb_seq_div;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         go = 1'b0;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Results the DUT should currently be publishing.
    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;

    seq_div #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .left       (left),
        .right      (right),
        .ready      (ready),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
`ifdef SEQ_DIV_ZERO_FLAG_EN
        ,
        .div_by_zero(div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input logic [W-1:0] l, input logic [W-1:0] r,
                                    output logic [W-1:0] q, output logic [W-1:0] rm);
        if (r == 0) begin
            q  = {W{1'b1}};
            rm = l;
        end else begin
            q  = l / r;
            rm = l % r;
        end
    endfunction

    // Called in cycle 0 (IDLE or DONE); the next edge accepts.
    task automatic start_op(input logic [W-1:0] l, input logic [W-1:0] r);
        go    = 1'b1;
        left  = l;
        right = r;
    endtask

    // Walks cycles 1..W; returns in the DONE cycle. ign_cyc>0 pulses a stray go.
    task automatic finish_op(input logic [W-1:0] l, input logic [W-1:0] r, input int ign_cyc);
        logic [W-1:0] q;
        logic [W-1:0] rm;
        ref_div(l, r, q, rm);
        for (int cyc = 1; cyc <= int'(W); cyc++) begin
            tick();
            go = (cyc == ign_cyc);
            if (cyc == ign_cyc) begin
                left  = W'(50);
                right = W'(5);
            end else begin
                left  = W'($urandom);
                right = W'($urandom);
            end
            if (cyc < int'(W)) begin
                check("ready_in_run", ready, 0);
                check("done_in_run", done, 0);
                check("q_hold_in_run", quotient, exp_q);
                check("r_hold_in_run", remainder, exp_r);
            end
        end
        go = 1'b0;
        check("done_pulse", done, 1);
        check("ready_in_done", ready, 1);
        check("quotient", quotient, q);
        check("remainder", remainder, rm);
`ifdef SEQ_DIV_ZERO_FLAG_EN
        check("div_by_zero", div_by_zero, (r == 0));
`endif
        exp_q = q;
        exp_r = rm;
    endtask

    task automatic end_op();
        go = 1'b0;
        tick();
        check("done_one_cycle", done, 0);
        check("ready_idle", ready, 1);
        check("q_held_idle", quotient, exp_q);
        check("r_held_idle", remainder, exp_r);
    endtask

    task automatic run_one(input logic [W-1:0] l, input logic [W-1:0] r);
        start_op(l, r);
        finish_op(l, r, 0);
        end_op();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_q", quotient, 0);
        check("reset_r", remainder, 0);
`ifdef SEQ_DIV_ZERO_FLAG_EN
        check("reset_dbz", div_by_zero, 0);
`endif

        run_one(W'(100), W'(7));
        run_one(W'(5), W'(0));
        run_one(W'(255), W'(1));
        run_one(W'(3), W'(200));
        run_one(W'(200), W'(200));

        // Stray go during RUN must be ignored.
        start_op(W'(100), W'(7));
        finish_op(W'(100), W'(7), 3);
        end_op();
        tick();
        check("no_second_done", done, 0);

        // Reset mid-run, with go also high on the same edge.
        start_op(W'(100), W'(7));
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            go = 1'b0;
        end
        reset = 1'b1;
        start_op(W'(9), W'(3));
        tick();
        reset = 1'b0;
        go = 1'b0;
        exp_q = '0;
        exp_r = '0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        for (int cyc = 0; cyc < int'(W) + 2; cyc++) begin
            tick();
            check("abort_no_done", done, 0);
            check("abort_stays_idle", ready, 1);
        end

        // Back-to-back: go held in the DONE cycle.
        start_op(W'(100), W'(7));
        finish_op(W'(100), W'(7), 0);
        start_op(W'(81), W'(9));
        finish_op(W'(81), W'(9), 0);
        end_op();

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] l;
            logic [W-1:0] r;
            int ign;
            l   = W'($urandom);
            r   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            ign = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0;
            start_op(l, r);
            finish_op(l, r, ign);
            if ($urandom_range(0, 1) == 0) begin
                end_op();
            end
        end
        end_op();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Iterative unsigned restoring divider, one quotient bit per cycle.
- Sequential inverse of the combinational multiplier primitive. Lives in the primitives library beside the comb and register primitives.
- Fixed, data-independent latency, so Filament signatures can describe it exactly: go at G, results available at G+WIDTH.

Parameters:
- WIDTH, 32, bit width of dividend, divisor, quotient and remainder; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start request; sampled on the rising edge.
- left  input  WIDTH  dividend; sampled only on the accepting edge.
- right  input  WIDTH  divisor; sampled only on the accepting edge.
- ready  output  1  high in IDLE and DONE; go is accepted only when ready=1.
- done  output  1  one-cycle pulse; quotient and remainder are valid.
- quotient  output  WIDTH  left / right (unsigned).
- remainder  output  WIDTH  left % right (unsigned).

Behaviour:
- Reset (synchronous, active-high; wins over go on the same edge): state=IDLE, ready=1, done=0, quotient=0, remainder=0, iteration counter=0.
- States:
  - IDLE: go=1 latches left into the dividend shift register and right into the divisor register, clears the partial remainder (WIDTH+1 bits) and the counter, then goes to RUN.
  - RUN: on each edge, partial remainder = {rem[WIDTH-1:0], dividend MSB}; dividend shifts left. If partial ≥ divisor: subtract, shift in quotient bit 1; else restore, shift in 0. Counter increments. On the WIDTH-th RUN edge, go to DONE.
  - DONE: done=1 for exactly this cycle. go=1 here is accepted as in IDLE (back-to-back, no bubble); else go to IDLE.
- Latency: accepting edge at cycle 0 → done high in cycle WIDTH. Throughput is one division per WIDTH cycles.
- quotient/remainder are registered outputs. They hold their values from DONE until the next accepted operation completes. They must not change during RUN.
- go while in RUN: ignored, no side effects. left/right changes during RUN: no effect.
- Divide by zero: same latency, no special path. The algorithm yields quotient = all ones (2^WIDTH-1) and remainder = left; this is required behaviour.
- Reset mid-RUN: the operation is aborted, all outputs return to reset values next cycle, and no done pulse is issued.
- The counter is $clog2(WIDTH+1) bits and must not wrap within one operation.

Optional Feature:
- Macro: SEQ_DIV_ZERO_FLAG_EN.
- Defined: adds output port div_by_zero (1 bit).
  - Registered on the accepting edge as (right==0).
  - Held with quotient/remainder; reset value 0.
- Undefined: no port and no extra logic. The port list is exactly as above.

Decomposition:
- Package seq_div_pkg:
  - state enum (IDLE, RUN, DONE), 2 bits.
  - function cnt_width(w) = $clog2(w+1).
- Sub-module seq_div_step (combinational, WIDTH parameter).
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
  - Contains no state; the FSM and registers stay in seq_div.

Test Plan:
- WIDTH=8, left=100, right=7, go at cycle 0 → done only in cycle 8, quotient=14, remainder=2, ready=0 in cycles 1..7.
- WIDTH=8, left=5, right=0 → done in cycle 8, quotient=255, remainder=5; div_by_zero=1 with SEQ_DIV_ZERO_FLAG_EN.
- WIDTH=8: 255/1 → q=255,r=0; then 3/200 → q=0,r=3; also 200/200 → q=1,r=0.
- WIDTH=8, 100/7 started, go with 50/5 pulsed in cycle 3 → ignored; result 14/2 in cycle 8, no second done.
- Reset asserted in cycle 4 of 100/7 → cycle 5 shows ready=1, done=0, q=r=0; no done pulse follows.
- WIDTH=8, go held high with new operands in the done cycle (cycle 8: 81/9) → first result 14/2 visible in cycle 8; second done in cycle 16 with q=9, r=0.
